pipe_hazard_ctrl: RTL

//  Central hazard/flush sequencer for the 5-stage pipeline. Drives stall/flush of PC, IF_ID, ID_EX, EX_MEM, MEM_WB.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_if.sv | 58 +++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg                                                        |
// | Shared types and constants for the pipeline hazard controller.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  REG_X0   = 5'd0;

  // x0 is hardwired to zero, so a producer writing it never creates a dependency
  function automatic logic reg_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd) && (rd != REG_X0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl_if                                                  |
// | Datapath <-> hazard controller signal bundle (perf counters under    |
// | PIPE_CTRL_PERF_EN). Rev 1.0                                          |
// +----------------------------------------------------------------------+
interface pipe_hazard_ctrl_if
`ifdef PIPE_CTRL_PERF_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic [4:0] rd_ex;
  logic       mem_read_ex;
  logic       br_taken_ex;
  logic       imem_ready;
  logic       dmem_req_mem;
  logic       dmem_ready;
  logic       halt_wb;
  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       stall_id_ex;
  logic       flush_id_ex;
  logic       stall_ex_mem;
  logic       stall_mem_wb;
  logic       mem_timeout;
  logic       halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
`endif

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           br_taken_ex, imem_ready, dmem_req_mem, dmem_ready, halt_wb,
    input  stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
           stall_ex_mem, stall_mem_wb, mem_timeout, halted
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cycles, flush_events
`endif
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
           br_taken_ex, imem_ready, dmem_req_mem, dmem_ready, halt_wb,
    output stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
           stall_ex_mem, stall_mem_wb, mem_timeout, halted
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cycles, flush_events
`endif
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_detect                                                        |
// | Combinational load-use dependency compare between ID and EX.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  wire logic [4:0] i_rs1_id,
  input  wire logic [4:0] i_rs2_id,
  input  wire logic       i_rs1_used_id,
  input  wire logic       i_rs2_used_id,
  input  wire logic [4:0] i_rd_ex,
  input  wire logic       i_mem_read_ex,
  output logic            o_load_use
);

  assign o_load_use = i_mem_read_ex &&
                      (reg_match(i_rs1_used_id, i_rs1_id, i_rd_ex) ||
                       reg_match(i_rs2_used_id, i_rs2_id, i_rd_ex));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                     |
// | Stall/flush sequencer for the 5-stage pipeline. Define               |
// | PIPE_CTRL_PERF_EN to add stall_cycles/flush_events counters.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
)
(
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int                  c_WCNT_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [c_WCNT_W-1:0] c_WAIT_MAX = c_WCNT_W'(WAIT_TIMEOUT);

  state_t              r_state, w_state_n;
  logic                r_pend, w_pend_n;
  logic [c_WCNT_W-1:0] r_wait_cnt, w_wait_cnt_n, w_wait_inc;
  logic                r_timeout, w_timeout_n;

  logic w_load_use, w_dmem_wait, w_br_flush;
  logic w_stall_pc, w_stall_if_id, w_flush_if_id, w_stall_id_ex, w_flush_id_ex;
  logic w_stall_ex_mem, w_stall_mem_wb, w_halted;

  hazard_detect u_hazard_detect (
    .i_rs1_id      (bus.rs1_id),
    .i_rs2_id      (bus.rs2_id),
    .i_rs1_used_id (bus.rs1_used_id),
    .i_rs2_used_id (bus.rs2_used_id),
    .i_rd_ex       (bus.rd_ex),
    .i_mem_read_ex (bus.mem_read_ex),
    .o_load_use    (w_load_use)
  );

  assign w_dmem_wait = bus.dmem_req_mem && !bus.dmem_ready;
  assign w_wait_inc  = (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_comb begin
    w_state_n      = r_state;
    w_pend_n       = r_pend;
    w_wait_cnt_n   = r_wait_cnt;
    w_timeout_n    = r_timeout;
    w_br_flush     = 1'b0;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_flush_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_stall_mem_wb = 1'b0;
    w_halted       = 1'b0;
    // Reset dominates every hazard source, so outputs stay quiet while it is held
    if (rst) begin
      case (r_state)
        HALT: begin
          {w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem, w_stall_mem_wb} = '1;
          w_halted = 1'b1;
        end
        MEM_WAIT: begin
          if (!bus.dmem_ready) begin
            {w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem, w_stall_mem_wb} = '1;
            w_wait_cnt_n = w_wait_inc;
            if (w_wait_inc == c_WAIT_MAX) w_timeout_n = 1'b1;
          end else begin
            w_wait_cnt_n = '0;
            w_state_n    = bus.halt_wb ? HALT : RUN;
          end
        end
        default: begin
          if (w_dmem_wait) begin
            {w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem, w_stall_mem_wb} = '1;
            w_state_n    = MEM_WAIT;
            w_wait_cnt_n = w_wait_inc;
            if (w_wait_inc == c_WAIT_MAX) w_timeout_n = 1'b1;
          end else begin
            w_wait_cnt_n = '0;
            if (bus.halt_wb) w_state_n = HALT;
            if (bus.br_taken_ex) begin
              w_flush_if_id = 1'b1;
              w_flush_id_ex = 1'b1;
              w_br_flush    = 1'b1;
              // a fetch still outstanding belongs to the wrong path
              w_pend_n      = !bus.imem_ready;
            end else if (w_load_use) begin
              w_stall_pc    = 1'b1;
              w_stall_if_id = 1'b1;
              w_flush_id_ex = 1'b1;
            end else if (bus.imem_ready) begin
              w_flush_if_id = r_pend;
              w_pend_n      = 1'b0;
            end else begin
              w_stall_pc    = 1'b1;
              w_flush_if_id = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RUN;
      r_pend     <= 1'b0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pend     <= w_pend_n;
      r_wait_cnt <= w_wait_cnt_n;
      r_timeout  <= w_timeout_n;
    end
  end

  assign bus.stall_pc     = w_stall_pc;
  assign bus.stall_if_id  = w_stall_if_id;
  assign bus.flush_if_id  = w_flush_if_id;
  assign bus.stall_id_ex  = w_stall_id_ex;
  assign bus.flush_id_ex  = w_flush_id_ex;
  assign bus.stall_ex_mem = w_stall_ex_mem;
  assign bus.stall_mem_wb = w_stall_mem_wb;
  assign bus.halted       = w_halted;
  assign bus.mem_timeout  = rst && r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_events;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall_pc) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_br_flush) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;
`endif

endmodule
`default_nettype wire
